// File: rtl/sram_scx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_scx_arbiter                                             |
// | Description : Round-robin arbiter sharing one single-port 32-bit,          |
// |               byte-writable SRAM between two SCx masters. Converts the     |
// |               winning request into SRAM pin controls and returns read data |
// |               (with a valid strobe) to the issuing master one cycle later. |
// |               Optional lock (macro SRAM_ARB_LOCK_EN) gives one master      |
// |               exclusive back-to-back access, bounded by TIMEOUT cycles.    |
// | Ports       : CLK, RST               clock / synchronous active-high reset |
// |               Mx_REQ/WT/BE/ADDR/WDT  SCx request, command and write data   |
// |               Mx_LOCK                lock request (lock build only)        |
// |               Mx_nWAIT               0 = request stalled                   |
// |               Mx_RVALID/Mx_RDT       read return (RDT is 0 when not valid) |
// |               SRAM_CSN/WEN/A/BWEN/DI SRAM pin controls (active-low strobes)|
// |               SRAM_DOUT              SRAM read data, valid cycle after read|
// |               FAULT                  one-cycle pulse on lock timeout       |
// | Macro       : SRAM_ARB_LOCK_EN       builds the LOCKED states and counter  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sram_scx_arbiter #(
    parameter int AWIDTH  = 11,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              M0_REQ,
    input  logic              M0_WT,
    input  logic [3:0]        M0_BE,
    input  logic [31:0]       M0_ADDR,
    input  logic [31:0]       M0_WDT,
    input  logic              M0_LOCK,
    output logic              M0_nWAIT,
    output logic              M0_RVALID,
    output logic [31:0]       M0_RDT,
    input  logic              M1_REQ,
    input  logic              M1_WT,
    input  logic [3:0]        M1_BE,
    input  logic [31:0]       M1_ADDR,
    input  logic [31:0]       M1_WDT,
    input  logic              M1_LOCK,
    output logic              M1_nWAIT,
    output logic              M1_RVALID,
    output logic [31:0]       M1_RDT,
    output logic              SRAM_CSN,
    output logic              SRAM_WEN,
    output logic [AWIDTH-1:0] SRAM_A,
    output logic [31:0]       SRAM_BWEN,
    output logic [31:0]       SRAM_DI,
    input  logic [31:0]       SRAM_DOUT,
    output logic              FAULT
);

    logic        r_ptr;          // master that wins a two-way contention
    logic        w_ptr_nxt;
    logic        r_rtag_vld;     // a read was accepted last cycle
    logic        r_rtag_id;      // ... and this master issued it
    logic        w_lk0;          // M0 currently owns the lock
    logic        w_lk1;          // M1 currently owns the lock
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any;
    logic        w_sel;          // winning master id (valid when w_any)
    logic        w_wt;
    logic [3:0]  w_be;
    logic [31:0] w_addr;
    logic [31:0] w_wdt;
    logic        w_fault;
    logic        w_unused;

    // Grant: nothing during reset; a lock owner excludes the other master;
    // otherwise a lone requester wins and a tie goes to r_ptr.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!RST) begin
            if (w_lk0) begin
                w_gnt0 = M0_REQ;
            end else if (w_lk1) begin
                w_gnt1 = M1_REQ;
            end else if (M0_REQ && M1_REQ) begin
                w_gnt0 = ~r_ptr;
                w_gnt1 = r_ptr;
            end else begin
                w_gnt0 = M0_REQ;
                w_gnt1 = M1_REQ;
            end
        end
    end

    assign w_any  = w_gnt0 | w_gnt1;
    assign w_sel  = w_gnt1;
    assign w_wt   = w_sel ? M1_WT   : M0_WT;
    assign w_be   = w_sel ? M1_BE   : M0_BE;
    assign w_addr = w_sel ? M1_ADDR : M0_ADDR;
    assign w_wdt  = w_sel ? M1_WDT  : M0_WDT;

    always_comb begin
        SRAM_CSN  = 1'b1;
        SRAM_WEN  = 1'b1;
        SRAM_A    = '0;
        SRAM_BWEN = '1;
        SRAM_DI   = '0;
        if (w_any) begin
            SRAM_CSN  = 1'b0;
            SRAM_WEN  = ~w_wt;
            SRAM_A    = w_addr[AWIDTH+1:2];
            SRAM_BWEN = ~{{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
            SRAM_DI   = w_wdt;
        end
    end

    assign M0_nWAIT = ~(M0_REQ & ~w_gnt0);
    assign M1_nWAIT = ~(M1_REQ & ~w_gnt1);

    // Read return is gated by RST so a read accepted just before reset
    // is dropped rather than delivered during the reset cycle.
    assign M0_RVALID = ~RST & r_rtag_vld & ~r_rtag_id;
    assign M1_RVALID = ~RST & r_rtag_vld &  r_rtag_id;
    assign M0_RDT    = M0_RVALID ? SRAM_DOUT : 32'h0;
    assign M1_RDT    = M1_RVALID ? SRAM_DOUT : 32'h0;
    assign FAULT     = w_fault & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr      <= 1'b0;
            r_rtag_vld <= 1'b0;
            r_rtag_id  <= 1'b0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_rtag_vld <= w_any & ~w_wt;
            r_rtag_id  <= w_sel;
        end
    end

`ifdef SRAM_ARB_LOCK_EN
    localparam logic [1:0] ST_RR  = 2'd0;
    localparam logic [1:0] ST_LK0 = 2'd1;
    localparam logic [1:0] ST_LK1 = 2'd2;
    localparam int         CW     = $clog2(TIMEOUT);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_lock;

    assign w_lk0  = (r_state == ST_LK0);
    assign w_lk1  = (r_state == ST_LK1);
    assign w_lock = w_sel ? M1_LOCK : M0_LOCK;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_RR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_fault     = 1'b0;
        case (r_state)
            ST_LK0, ST_LK1: begin
                // Counter runs every locked cycle, requested or not.
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_any && !w_lock) begin
                    // Final locked access; takes precedence over a timeout.
                    w_state_nxt = ST_RR;
                    w_ptr_nxt   = ~w_sel;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = ST_RR;
                    w_ptr_nxt   = (r_state == ST_LK0);
                    w_fault     = 1'b1;
                end
            end
            default: begin
                if (w_any) begin
                    w_ptr_nxt = ~w_sel;
                    if (w_lock) begin
                        w_state_nxt = w_sel ? ST_LK1 : ST_LK0;
                        w_cnt_nxt   = '0;
                    end
                end
            end
        endcase
    end

    assign w_unused = &{1'b0, M0_ADDR, M1_ADDR};
`else
    assign w_lk0   = 1'b0;
    assign w_lk1   = 1'b0;
    assign w_fault = 1'b0;

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_any) begin
            w_ptr_nxt = ~w_sel;
        end
    end

    assign w_unused = &{1'b0, M0_ADDR, M1_ADDR, M0_LOCK, M1_LOCK, (TIMEOUT >= 2)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_scx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sram_scx_arbiter                                          |
// | Description : Self-checking bench for sram_scx_arbiter with a behavioural  |
// |               write-first single-port SRAM model.                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sram_scx_arbiter;

    localparam int          AW   = 11;
    localparam logic        H    = 1'b1;
    localparam logic        L    = 1'b0;
    localparam logic [3:0]  Z4   = 4'h0;
    localparam logic [31:0] Z32  = 32'h0;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam logic [AW-1:0] ZA = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_wt, m0_lock, m0_nwait, m0_rvalid;
    logic [3:0]    m0_be;
    logic [31:0]   m0_addr, m0_wdt, m0_rdt;
    logic          m1_req, m1_wt, m1_lock, m1_nwait, m1_rvalid;
    logic [3:0]    m1_be;
    logic [31:0]   m1_addr, m1_wdt, m1_rdt;
    logic          sram_csn, sram_wen, fault;
    logic [AW-1:0] sram_a;
    logic [31:0]   sram_bwen, sram_di, sram_dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_scx_arbiter #(.AWIDTH(AW), .TIMEOUT(16)) dut (
        .CLK(clk), .RST(rst),
        .M0_REQ(m0_req), .M0_WT(m0_wt), .M0_BE(m0_be), .M0_ADDR(m0_addr),
        .M0_WDT(m0_wdt), .M0_LOCK(m0_lock), .M0_nWAIT(m0_nwait),
        .M0_RVALID(m0_rvalid), .M0_RDT(m0_rdt),
        .M1_REQ(m1_req), .M1_WT(m1_wt), .M1_BE(m1_be), .M1_ADDR(m1_addr),
        .M1_WDT(m1_wdt), .M1_LOCK(m1_lock), .M1_nWAIT(m1_nwait),
        .M1_RVALID(m1_rvalid), .M1_RDT(m1_rdt),
        .SRAM_CSN(sram_csn), .SRAM_WEN(sram_wen), .SRAM_A(sram_a),
        .SRAM_BWEN(sram_bwen), .SRAM_DI(sram_di), .SRAM_DOUT(sram_dout),
        .FAULT(fault)
    );

    // Single-port SRAM, write-first: a write also drives the new word out.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!sram_csn) begin
            if (!sram_wen) begin
                mem[sram_a] <= (mem[sram_a] & sram_bwen) | (sram_di & ~sram_bwen);
                sram_dout   <= (mem[sram_a] & sram_bwen) | (sram_di & ~sram_bwen);
            end else begin
                sram_dout <= mem[sram_a];
            end
        end
    end

    typedef struct packed {
        logic        r0;  logic w0;  logic [3:0] be0; logic [31:0] a0; logic [31:0] d0;
        logic        r1;  logic w1;  logic [3:0] be1; logic [31:0] a1; logic [31:0] d1;
        logic        nw0; logic nw1; logic csn; logic wen;
        logic [AW-1:0] ea; logic [31:0] bwen; logic [31:0] di;
        logic        rv0; logic [31:0] rdt0; logic rv1; logic [31:0] rdt1;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic set_m0(input logic r, input logic w, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] d, input logic lk);
        m0_req = r; m0_wt = w; m0_be = be; m0_addr = a; m0_wdt = d; m0_lock = lk;
    endtask

    task automatic set_m1(input logic r, input logic w, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] d, input logic lk);
        m1_req = r; m1_wt = w; m1_be = be; m1_addr = a; m1_wdt = d; m1_lock = lk;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // write/read, byte enables, contention with alternating grant, RAW, upper address bits
        vecs[0]  = '{H,H,4'hF,32'h40,32'hDEADBEEF, L,L,Z4,Z32,Z32, H,H,L,L,11'h010,Z32,32'hDEADBEEF, L,Z32,L,Z32};
        vecs[1]  = '{H,L,Z4,32'h40,Z32, L,L,Z4,Z32,Z32, H,H,L,H,11'h010,ONES,Z32, L,Z32,L,Z32};
        vecs[2]  = '{L,L,Z4,Z32,Z32, L,L,Z4,Z32,Z32, H,H,H,H,ZA,ONES,Z32, H,32'hDEADBEEF,L,Z32};
        vecs[3]  = '{L,L,Z4,Z32,Z32, H,H,4'hF,32'h80,32'h11223344, H,H,L,L,11'h020,Z32,32'h11223344, L,Z32,L,Z32};
        vecs[4]  = '{L,L,Z4,Z32,Z32, H,H,4'h2,32'h80,32'h0000AB00, H,H,L,L,11'h020,32'hFFFF00FF,32'h0000AB00, L,Z32,L,Z32};
        vecs[5]  = '{L,L,Z4,Z32,Z32, H,L,Z4,32'h80,Z32, H,H,L,H,11'h020,ONES,Z32, L,Z32,L,Z32};
        vecs[6]  = '{L,L,Z4,Z32,Z32, L,L,Z4,Z32,Z32, H,H,H,H,ZA,ONES,Z32, L,Z32,H,32'h1122AB44};
        vecs[7]  = '{H,L,Z4,32'h40,Z32, H,L,Z4,32'h80,Z32, H,L,L,H,11'h010,ONES,Z32, L,Z32,L,Z32};
        vecs[8]  = '{H,L,Z4,32'h40,Z32, H,L,Z4,32'h80,Z32, L,H,L,H,11'h020,ONES,Z32, H,32'hDEADBEEF,L,Z32};
        vecs[9]  = '{H,L,Z4,32'h40,Z32, H,H,4'hF,32'h84,32'hCAFEF00D, H,L,L,H,11'h010,ONES,Z32, L,Z32,H,32'h1122AB44};
        vecs[10] = '{H,L,Z4,32'h84,Z32, H,H,4'hF,32'h84,32'hCAFEF00D, L,H,L,L,11'h021,Z32,32'hCAFEF00D, H,32'hDEADBEEF,L,Z32};
        vecs[11] = '{H,L,Z4,32'h84,Z32, H,L,Z4,32'hFFFFE080,Z32, H,L,L,H,11'h021,ONES,Z32, L,Z32,L,Z32};
        vecs[12] = '{L,L,Z4,Z32,Z32, H,L,Z4,32'hFFFFE080,Z32, H,H,L,H,11'h020,ONES,Z32, H,32'hCAFEF00D,L,Z32};
        vecs[13] = '{L,L,Z4,Z32,Z32, L,L,Z4,Z32,Z32, H,H,H,H,ZA,ONES,Z32, L,Z32,H,32'h1122AB44};

        // reset state
        rst = 1'b1;
        set_m0(H, L, Z4, Z32, Z32, L);
        set_m1(L, L, Z4, Z32, Z32, L);
        tick; tick;
        @(negedge clk);
        chk1("rst nwait0", m0_nwait, L);
        chk1("rst nwait1", m1_nwait, H);
        chk1("rst csn", sram_csn, H);
        chk1("rst wen", sram_wen, H);
        chk("rst bwen", sram_bwen, ONES);
        chk1("rst rvalid0", m0_rvalid, L);
        chk("rst rdt0", m0_rdt, Z32);
        chk1("rst rvalid1", m1_rvalid, L);
        chk1("rst fault", fault, L);
        tick;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            set_m0(vecs[i].r0, vecs[i].w0, vecs[i].be0, vecs[i].a0, vecs[i].d0, L);
            set_m1(vecs[i].r1, vecs[i].w1, vecs[i].be1, vecs[i].a1, vecs[i].d1, L);
            @(negedge clk);
            chk1($sformatf("v%0d nwait0", i), m0_nwait, vecs[i].nw0);
            chk1($sformatf("v%0d nwait1", i), m1_nwait, vecs[i].nw1);
            chk1($sformatf("v%0d csn", i), sram_csn, vecs[i].csn);
            chk1($sformatf("v%0d wen", i), sram_wen, vecs[i].wen);
            chk($sformatf("v%0d addr", i), {21'b0, sram_a}, {21'b0, vecs[i].ea});
            chk($sformatf("v%0d bwen", i), sram_bwen, vecs[i].bwen);
            chk($sformatf("v%0d di", i), sram_di, vecs[i].di);
            chk1($sformatf("v%0d rvalid0", i), m0_rvalid, vecs[i].rv0);
            chk($sformatf("v%0d rdt0", i), m0_rdt, vecs[i].rdt0);
            chk1($sformatf("v%0d rvalid1", i), m1_rvalid, vecs[i].rv1);
            chk($sformatf("v%0d rdt1", i), m1_rdt, vecs[i].rdt1);
            chk1($sformatf("v%0d fault", i), fault, L);
            tick;
        end

        // M0 alone so that M1 holds priority next
        set_m0(H, H, 4'hF, 32'h100, 32'h5555AAAA, L);
        set_m1(L, L, Z4, Z32, Z32, L);
        @(negedge clk);
        chk1("pre nwait0", m0_nwait, H);
        tick;

`ifdef SRAM_ARB_LOCK_EN
        // lock hold: M1 LOCK=1,1,0 while M0 requests throughout
        for (int k = 0; k < 3; k++) begin
            set_m0(H, L, Z4, 32'h40, Z32, L);
            set_m1(H, H, 4'hF, 32'h104 + 32'(4 * k), 32'h1000 + 32'(k), (k < 2));
            @(negedge clk);
            chk1($sformatf("lk%0d nwait0", k), m0_nwait, L);
            chk1($sformatf("lk%0d nwait1", k), m1_nwait, H);
            chk($sformatf("lk%0d addr", k), {21'b0, sram_a}, 32'h41 + 32'(k));
            chk1($sformatf("lk%0d fault", k), fault, L);
            tick;
        end
        set_m1(H, H, 4'hF, 32'h110, Z32, L);
        @(negedge clk);
        chk1("lk3 nwait0", m0_nwait, H);
        chk1("lk3 nwait1", m1_nwait, L);
        chk("lk3 addr", {21'b0, sram_a}, 32'h10);
        tick;
        set_m0(L, L, Z4, Z32, Z32, L);
        @(negedge clk);
        chk1("lk4 nwait1", m1_nwait, H);
        chk("lk4 addr", {21'b0, sram_a}, 32'h44);
        chk("lk4 rdt0", m0_rdt, 32'hDEADBEEF);
        tick;

        // lock timeout: M0 locks once then goes quiet while M1 waits
        set_m0(H, L, Z4, 32'h40, Z32, H);
        set_m1(L, L, Z4, Z32, Z32, L);
        @(negedge clk);
        chk1("to entry nwait0", m0_nwait, H);
        tick;
        set_m0(L, L, Z4, Z32, Z32, L);
        set_m1(H, L, Z4, 32'h80, Z32, L);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk1($sformatf("to%0d nwait1", k), m1_nwait, (k == 17));
            chk1($sformatf("to%0d fault", k), fault, (k == 16));
            if (k == 1) chk("to1 rdt0", m0_rdt, 32'hDEADBEEF);
            tick;
        end

        // release in the timeout cycle beats the timeout
        set_m0(H, L, Z4, 32'h40, Z32, H);
        set_m1(L, L, Z4, Z32, Z32, L);
        @(negedge clk);
        chk1("rl entry nwait0", m0_nwait, H);
        tick;
        set_m1(H, L, Z4, 32'h80, Z32, L);
        for (int k = 1; k <= 17; k++) begin
            if (k <= 16) set_m0(H, L, Z4, 32'h40, Z32, (k < 16));
            else         set_m0(L, L, Z4, Z32, Z32, L);
            @(negedge clk);
            chk1($sformatf("rl%0d nwait0", k), m0_nwait, H);
            chk1($sformatf("rl%0d nwait1", k), m1_nwait, (k == 17));
            chk1($sformatf("rl%0d fault", k), fault, L);
            tick;
        end
`else
        // lock inputs are ignored: strict alternation continues
        set_m0(H, L, Z4, 32'h40, Z32, H);
        set_m1(H, H, 4'hF, 32'h104, 32'h1000, H);
        @(negedge clk);
        chk1("nl0 nwait0", m0_nwait, L);
        chk1("nl0 nwait1", m1_nwait, H);
        tick;
        set_m1(H, H, 4'hF, 32'h108, 32'h1001, H);
        @(negedge clk);
        chk1("nl1 nwait0", m0_nwait, H);
        chk1("nl1 nwait1", m1_nwait, L);
        chk1("nl1 fault", fault, L);
        tick;
`endif

        // reset in the cycle after M1's read is accepted
        set_m0(L, L, Z4, Z32, Z32, L);
        set_m1(H, L, Z4, 32'h80, Z32, L);
        @(negedge clk);
        chk1("rr nwait1", m1_nwait, H);
        tick;
        rst = 1'b1;
        set_m0(H, L, Z4, 32'h40, Z32, L);
        @(negedge clk);
        chk1("rr rvalid1", m1_rvalid, L);
        chk("rr rdt1", m1_rdt, Z32);
        chk1("rr csn", sram_csn, H);
        chk1("rr nwait0", m0_nwait, L);
        chk1("rr nwait1", m1_nwait, L);
        chk1("rr fault", fault, L);
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk1("ra nwait0", m0_nwait, H);
        chk1("ra nwait1", m1_nwait, L);
        chk("ra addr", {21'b0, sram_a}, 32'h10);
        tick;

        // priority returns to M0 after a reset even when M1 was next
        set_m0(L, L, Z4, Z32, Z32, L);
        set_m1(L, L, Z4, Z32, Z32, L);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        set_m0(H, L, Z4, 32'h40, Z32, L);
        set_m1(H, L, Z4, 32'h80, Z32, L);
        @(negedge clk);
        chk1("rb nwait0", m0_nwait, H);
        chk1("rb nwait1", m1_nwait, L);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_scx_arbiter.md
# sram_scx_arbiter

Two-requester arbiter that shares one single-port SRAM macro (SPSRAM, word-addressed, 32-bit, byte-writable) between two SCx-style masters, e.g. the external-interface receiver and a local engine. It grants one access per clock using round-robin priority. It converts the winning SCx request into SRAM pin controls and returns read data, tagged with a valid strobe, to the issuing master. An optional lock mechanism gives one master exclusive back-to-back access, guarded by a timeout.

## Interface
- AWIDTH, 11: SRAM word-address width. SRAM holds 2^AWIDTH words.
- TIMEOUT, 16: maximum cycles a lock may be held before forced release. Must be ≥2.

- CLK  in  1: clock. Also drives the SRAM CK.
- RST  in  1: reset, synchronous, active-high.
- Mx_REQ  in  1 (x=0,1): access request. Held, with the command stable, until accepted.
- Mx_WT  in  1: 1 = write, 0 = read.
- Mx_BE  in  4: byte enables. Bit i covers WDT[8i+7:8i].
- Mx_ADDR  in  32: byte address. Bits [AWIDTH+1:2] are used; the rest are ignored.
- Mx_WDT  in  32: write data.
- Mx_LOCK  in  1: request lock with this access (only used with SRAM_ARB_LOCK_EN).
- Mx_nWAIT  out  1: 0 = request stalled. REQ=1 with nWAIT=1 means accepted this cycle.
- Mx_RVALID  out  1: read data valid for Mx.
- Mx_RDT  out  32: read data. 0 when RVALID=0.
- SRAM_CSN  out  1: chip select, active-low.
- SRAM_WEN  out  1: write enable, active-low.
- SRAM_A  out  AWIDTH: word address.
- SRAM_BWEN  out  32: bit write enables, active-low.
- SRAM_DI  out  32: write data.
- SRAM_DOUT  in  32: read data. Valid in the cycle after a read access.
- FAULT  out  1: one-cycle pulse on lock timeout.

## Operation
- Registered state: priority pointer PTR (0/1), FSM state, lock counter, read-return tag RTAG (valid + master id).
- Grant is combinational from the REQ inputs, PTR and the FSM state.
  - One requester: it wins.
  - Two requesters: master PTR wins.
- SRAM signals for the winner:
  - CSN=0.
  - WEN=~WT.
  - A=ADDR[AWIDTH+1:2].
  - BWEN=~{{8{BE[3]}},{8{BE[2]}},{8{BE[1]}},{8{BE[0]}}}.
  - DI=WDT.
- With no winner: CSN=1, WEN=1, BWEN=all 1s, A=0, DI=0.
- nWAIT:
  - Mx_nWAIT = ~(Mx_REQ & ~GNTx).
  - An idle master sees nWAIT=1.
- After an accepted access, PTR moves to the other master (outside LOCKED).
- Read return:
  - An accepted read sets RTAG.
  - In the next cycle, that master gets RVALID=1 and RDT=SRAM_DOUT.
  - Writes produce no RVALID.
- FSM states:
  - IDLE/RR: normal round-robin arbitration.
  - LOCKED_M0 / LOCKED_M1: present only with the lock macro.
- Entering lock: from RR, an accepted access with LOCK=1 enters LOCKED_Mx and clears the counter.
- In LOCKED_Mx:
  - Only Mx can be granted. The other master stalls.
  - The counter increments every cycle, whether or not Mx requests.
  - An accepted Mx access with LOCK=0 is the final locked access. It returns to RR with PTR=other.
  - If the counter reaches TIMEOUT-1 with no such release, the FSM returns to RR with PTR=other and pulses FAULT=1 for one cycle.
  - An access accepted in the timeout cycle completes normally.
- Simultaneous release and timeout: the release wins and FAULT stays 0.

## Timing
- Reset values:
  - Registered state: PTR=0, state=RR, counter=0, RTAG invalid.
  - Outputs: RVALID=0, RDT=0, FAULT=0, CSN=1, WEN=1, BWEN=all 1s.
- While RST=1:
  - No grants.
  - Mx_nWAIT = ~Mx_REQ.
- Access latency:
  - Acceptance happens in cycle N, and the SRAM samples at the end of N.
  - Read data is valid in N+1.
- Throughput: one access per cycle, back-to-back, including alternating masters.
- A read accepted in cycle N, with RST asserted in N+1: RVALID is 0 in N+1 and the data is dropped.
- Read-after-write to the same address in consecutive cycles returns the new data. This follows from SPSRAM write-first behaviour.

## Configuration
- SRAM_ARB_LOCK_EN
  - Defined: LOCK inputs are honoured, and the LOCKED states, lock counter and FAULT are built.
  - Undefined:
    - LOCK inputs are ignored.
    - FSM is pure round-robin.
    - FAULT is tied to 0.
    - TIMEOUT is unused.

## Test plan
- Single-master write then read:
  - M0 writes A=0x40, WDT=0xDEADBEEF, BE=0xF, then reads 0x40.
  - Required: nWAIT=1 in both acceptance cycles, and M0_RVALID=1 with RDT=0xDEADBEEF one cycle after the read.
- Contention:
  - Both masters assert REQ continuously right after reset.
  - Required: M0 is granted in cycle 0, then M1, M0, M1… The loser sees nWAIT=0 each cycle, and RVALID goes to the correct master.
- Byte enables:
  - Write 0x11223344, then write BE=0x2 with WDT=0x0000AB00, then read.
  - Required: read returns 0x1122AB44.
- Lock hold (SRAM_ARB_LOCK_EN):
  - M1 performs 3 accesses with LOCK=1,1,0 while M0 requests continuously.
  - Required: M0 nWAIT=0 for those 3 cycles, and M0 is granted in the next cycle.
- Lock timeout (TIMEOUT=16):
  - M0 performs one access with LOCK=1, then drops REQ while M1 requests.
  - Required: FAULT pulses in cycle 16 of the lock, and M1 is granted in the following cycle.
- Reset mid-read:
  - RST=1 in the cycle after M1's read is accepted.
  - Required: M1_RVALID=0, CSN=1, and after reset the first contention is granted to M0.
